// File: rtl/rocc_mem_arbiter.sv
// rocc_mem_arbiter: shares one RoCC L1 D-cache port among NREQ engines with round-robin
// arbitration, source-ID tag prefixing, response steering and per-source load throttling.
// Optional per-source grant statistics are built when ROCC_MEM_ARB_STATS_EN is defined.
module rocc_mem_arbiter #(
    parameter int NREQ    = 2,
    parameter int TAGW    = 8,
    parameter int MAX_OUT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      in_req_valid,
    output logic [NREQ-1:0]      in_req_ready,
    input  logic [NREQ*40-1:0]   in_req_addr,
    input  logic [NREQ*TAGW-1:0] in_req_tag,
    input  logic [NREQ*5-1:0]    in_req_cmd,
    input  logic [NREQ*3-1:0]    in_req_typ,
    input  logic [NREQ*64-1:0]   in_req_data,
    input  logic                 io_mem_req_ready,
    output logic                 io_mem_req_valid,
    output logic [39:0]          io_mem_req_bits_addr,
    output logic [9:0]           io_mem_req_bits_tag,
    output logic [4:0]           io_mem_req_bits_cmd,
    output logic [2:0]           io_mem_req_bits_typ,
    output logic                 io_mem_req_bits_phys,
    output logic [63:0]          io_mem_req_bits_data,
    input  logic                 io_mem_resp_valid,
    input  logic [9:0]           io_mem_resp_bits_tag,
    input  logic [63:0]          io_mem_resp_bits_data,
    output logic [NREQ-1:0]      in_resp_valid,
    output logic [TAGW-1:0]      in_resp_tag,
    output logic [63:0]          in_resp_data,
    output logic                 io_busy
`ifdef ROCC_MEM_ARB_STATS_EN
    ,
    input  logic                 stat_clear,
    output logic [NREQ*16-1:0]   io_stat_grants
`endif
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [1:0]      grant_q, grant_d;
    logic [3:0]      cnt_q [NREQ];
    logic [3:0]      cnt_d [NREQ];

    logic [NREQ-1:0] elig_s;
    logic            any_elig_s;
    logic [1:0]      winner_s;
    int              best_dist_s;
    int              dist_s;
    logic [1:0]      sel_s;
    logic            sel_valid_s;
    logic [39:0]     sel_addr_s;
    logic [TAGW-1:0] sel_tag_s;
    logic [4:0]      sel_cmd_s;
    logic [2:0]      sel_typ_s;
    logic [63:0]     sel_data_s;
    logic            req_valid_s;
    logic            fire_s;
    logic [NREQ-1:0] resp_hit_s;
    logic            any_cnt_s;

    // Eligibility: valid and below the outstanding-load limit.
    always_comb begin
        elig_s    = {NREQ{1'b0}};
        any_cnt_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            elig_s[i] = in_req_valid[i] && (cnt_q[i] < 4'(MAX_OUT));
            any_cnt_s = any_cnt_s || (cnt_q[i] != 4'd0);
        end
        any_elig_s = |elig_s;
    end

    // Round-robin pick: the eligible source nearest after rr_ptr wins.
    always_comb begin
        winner_s    = rr_ptr_q;
        best_dist_s = NREQ;
        dist_s      = 0;
        for (int i = 0; i < NREQ; i++) begin
            dist_s = (i + 2 * NREQ - int'(rr_ptr_q) - 1) % NREQ;
            if (elig_s[i] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                winner_s    = 2'(i);
            end else begin
                best_dist_s = best_dist_s;
            end
        end
    end

    // Request mux: a locked grant overrides arbitration while a request is stalled.
    always_comb begin
        sel_s       = (state_q == S_HOLD) ? grant_q : winner_s;
        sel_valid_s = 1'b0;
        sel_addr_s  = 40'd0;
        sel_tag_s   = {TAGW{1'b0}};
        sel_cmd_s   = 5'd0;
        sel_typ_s   = 3'd0;
        sel_data_s  = 64'd0;
        for (int i = 0; i < NREQ; i++) begin
            sel_valid_s = sel_valid_s | ((sel_s == 2'(i)) & in_req_valid[i]);
            sel_addr_s  = sel_addr_s | ({40{sel_s == 2'(i)}} & in_req_addr[40*i +: 40]);
            sel_tag_s   = sel_tag_s  | ({TAGW{sel_s == 2'(i)}} & in_req_tag[TAGW*i +: TAGW]);
            sel_cmd_s   = sel_cmd_s  | ({5{sel_s == 2'(i)}} & in_req_cmd[5*i +: 5]);
            sel_typ_s   = sel_typ_s  | ({3{sel_s == 2'(i)}} & in_req_typ[3*i +: 3]);
            sel_data_s  = sel_data_s | ({64{sel_s == 2'(i)}} & in_req_data[64*i +: 64]);
        end
        if (reset) begin
            req_valid_s = 1'b0;
        end else if (state_q == S_HOLD) begin
            req_valid_s = sel_valid_s;
        end else begin
            req_valid_s = any_elig_s;
        end
        fire_s = req_valid_s && io_mem_req_ready;
    end

    // Downstream request and per-source handshake outputs.
    always_comb begin
        io_mem_req_valid     = req_valid_s;
        io_mem_req_bits_addr = sel_addr_s;
        io_mem_req_bits_tag  = {sel_s, 8'(sel_tag_s)};
        io_mem_req_bits_cmd  = sel_cmd_s;
        io_mem_req_bits_typ  = sel_typ_s;
        io_mem_req_bits_phys = 1'b1;
        io_mem_req_bits_data = sel_data_s;
        in_req_ready         = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            in_req_ready[i] = fire_s && (sel_s == 2'(i));
        end
        io_busy = !reset && (req_valid_s || any_cnt_s);
    end

    // Response steering by the source ID held in the top tag bits.
    always_comb begin
        resp_hit_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            resp_hit_s[i] = !reset && io_mem_resp_valid && (io_mem_resp_bits_tag[9:8] == 2'(i));
        end
        in_resp_valid = resp_hit_s;
        in_resp_tag   = TAGW'(io_mem_resp_bits_tag[7:0]);
        in_resp_data  = io_mem_resp_bits_data;
    end

    // Arbiter next state: a stall locks the winner until it fires or withdraws.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        case (state_q)
            S_IDLE: begin
                if (fire_s) begin
                    rr_ptr_d = winner_s;
                end else if (req_valid_s) begin
                    grant_d = winner_s;
                    state_d = S_HOLD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (fire_s) begin
                    rr_ptr_d = grant_q;
                    state_d  = S_IDLE;
                end else if (!sel_valid_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outstanding counters: a coincident fire and response cancel; decrement saturates at 0.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            case ({in_req_ready[i], resp_hit_s[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + 4'd1;
                2'b01:   cnt_d[i] = (cnt_q[i] == 4'd0) ? 4'd0 : (cnt_q[i] - 4'd1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= 2'(NREQ - 1);
            grant_q  <= 2'd0;
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= 4'd0;
            end
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef ROCC_MEM_ARB_STATS_EN
    logic [15:0] stat_q [NREQ];
    logic [15:0] stat_d [NREQ];

    // Grant statistics: clear wins over increment; counts stick at all-ones.
    always_comb begin
        io_stat_grants = {(NREQ*16){1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (stat_clear) begin
                stat_d[i] = 16'd0;
            end else if (in_req_ready[i] && (stat_q[i] != 16'hFFFF)) begin
                stat_d[i] = stat_q[i] + 16'd1;
            end else begin
                stat_d[i] = stat_q[i];
            end
            io_stat_grants[16*i +: 16] = stat_q[i];
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                stat_q[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                stat_q[i] <= stat_d[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_rocc_mem_arbiter.sv
// Self-checking bench for rocc_mem_arbiter (NREQ=2, TAGW=8, MAX_OUT=4): response-decode
// vector table, directed corner sequences, then randomized traffic against a reference model.
module tb_rocc_mem_arbiter;

    localparam int NREQ    = 2;
    localparam int TAGW    = 8;
    localparam int MAX_OUT = 4;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      in_req_valid;
    logic [NREQ-1:0]      in_req_ready;
    logic [NREQ*40-1:0]   in_req_addr;
    logic [NREQ*TAGW-1:0] in_req_tag;
    logic [NREQ*5-1:0]    in_req_cmd;
    logic [NREQ*3-1:0]    in_req_typ;
    logic [NREQ*64-1:0]   in_req_data;
    logic                 io_mem_req_ready;
    logic                 io_mem_req_valid;
    logic [39:0]          io_mem_req_bits_addr;
    logic [9:0]           io_mem_req_bits_tag;
    logic [4:0]           io_mem_req_bits_cmd;
    logic [2:0]           io_mem_req_bits_typ;
    logic                 io_mem_req_bits_phys;
    logic [63:0]          io_mem_req_bits_data;
    logic                 io_mem_resp_valid;
    logic [9:0]           io_mem_resp_bits_tag;
    logic [63:0]          io_mem_resp_bits_data;
    logic [NREQ-1:0]      in_resp_valid;
    logic [TAGW-1:0]      in_resp_tag;
    logic [63:0]          in_resp_data;
    logic                 io_busy;
`ifdef ROCC_MEM_ARB_STATS_EN
    logic                 stat_clear;
    logic [NREQ*16-1:0]   io_stat_grants;
`endif

    rocc_mem_arbiter #(.NREQ(NREQ), .TAGW(TAGW), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .reset(reset),
        .in_req_valid(in_req_valid), .in_req_ready(in_req_ready),
        .in_req_addr(in_req_addr), .in_req_tag(in_req_tag), .in_req_cmd(in_req_cmd),
        .in_req_typ(in_req_typ), .in_req_data(in_req_data),
        .io_mem_req_ready(io_mem_req_ready), .io_mem_req_valid(io_mem_req_valid),
        .io_mem_req_bits_addr(io_mem_req_bits_addr), .io_mem_req_bits_tag(io_mem_req_bits_tag),
        .io_mem_req_bits_cmd(io_mem_req_bits_cmd), .io_mem_req_bits_typ(io_mem_req_bits_typ),
        .io_mem_req_bits_phys(io_mem_req_bits_phys), .io_mem_req_bits_data(io_mem_req_bits_data),
        .io_mem_resp_valid(io_mem_resp_valid), .io_mem_resp_bits_tag(io_mem_resp_bits_tag),
        .io_mem_resp_bits_data(io_mem_resp_bits_data),
        .in_resp_valid(in_resp_valid), .in_resp_tag(in_resp_tag), .in_resp_data(in_resp_data),
        .io_busy(io_busy)
`ifdef ROCC_MEM_ARB_STATS_EN
        , .stat_clear(stat_clear), .io_stat_grants(io_stat_grants)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Per-source request fields as the bench intends them
    logic        r_v    [NREQ];
    logic [39:0] r_addr [NREQ];
    logic [7:0]  r_tag  [NREQ];
    logic [4:0]  r_cmd  [NREQ];
    logic [2:0]  r_typ  [NREQ];
    logic [63:0] r_data [NREQ];

    typedef struct {
        logic        rv;
        logic [9:0]  tag;
        logic [63:0] data;
        logic [1:0]  exp_v;
        logic [7:0]  exp_tag;
    } resp_vec_t;
    resp_vec_t rtab [6];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply();
        for (int s = 0; s < NREQ; s++) begin
            in_req_valid[s]          = r_v[s];
            in_req_addr[40*s +: 40]  = r_addr[s];
            in_req_tag[8*s +: 8]     = r_tag[s];
            in_req_cmd[5*s +: 5]     = r_cmd[s];
            in_req_typ[3*s +: 3]     = r_typ[s];
            in_req_data[64*s +: 64]  = r_data[s];
        end
    endtask

    task automatic setreq(input int s, input logic v, input logic [7:0] t);
        r_v[s]    = v;
        r_tag[s]  = t;
        r_addr[s] = {32'h0000_1000 + 32'(s), t};
        r_cmd[s]  = t[4:0];
        r_typ[s]  = t[2:0];
        r_data[s] = {48'h0, 8'(s), t};
    endtask

    task automatic idle_inputs();
        for (int s = 0; s < NREQ; s++) setreq(s, 1'b0, 8'h00);
        apply();
        io_mem_req_ready      = 1'b0;
        io_mem_resp_valid     = 1'b0;
        io_mem_resp_bits_tag  = 10'd0;
        io_mem_resp_bits_data = 64'd0;
`ifdef ROCC_MEM_ARB_STATS_EN
        stat_clear            = 1'b0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic resp(input logic v, input logic [9:0] t);
        io_mem_resp_valid     = v;
        io_mem_resp_bits_tag  = t;
        io_mem_resp_bits_data = {54'h0, t};
    endtask

    // Reference model state
    int   m_cnt [NREQ];
    int   m_last;
    int   m_lock;
    bit   ev;
    int   es;
    bit   efire;
    int   rid;
    logic [1:0] er;
    logic [1:0] erv;

    initial begin
        rtab[0] = '{1'b1, 10'h005, 64'h1111_0000_0000_0005, 2'b01, 8'h05};
        rtab[1] = '{1'b1, 10'h1A5, 64'h2222_0000_0000_00A5, 2'b10, 8'hA5};
        rtab[2] = '{1'b1, 10'h2FF, 64'h3333_0000_0000_00FF, 2'b00, 8'hFF};
        rtab[3] = '{1'b1, 10'h300, 64'h4444_0000_0000_0000, 2'b00, 8'h00};
        rtab[4] = '{1'b0, 10'h012, 64'h5555_0000_0000_0012, 2'b00, 8'h12};
        rtab[5] = '{1'b1, 10'h100, 64'h6666_0000_0000_0100, 2'b10, 8'h00};

        // Reset state, with requests and a response driven while reset is held
        reset = 1'b1;
        idle_inputs();
        setreq(0, 1'b1, 8'h11); setreq(1, 1'b1, 8'h22); apply();
        io_mem_req_ready = 1'b1;
        resp(1'b1, 10'h001);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_req_valid", io_mem_req_valid, 1'b0);
        chk("reset_req_ready", in_req_ready, 2'b00);
        chk("reset_resp_valid", in_resp_valid, 2'b00);
        chk("reset_busy", io_busy, 1'b0);
        chk("phys_const", io_mem_req_bits_phys, 1'b1);
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;

        // Response decode table; counters start at 0 so every decrement must saturate
        for (int v = 0; v < 6; v++) begin
            resp(rtab[v].rv, rtab[v].tag);
            io_mem_resp_bits_data = rtab[v].data;
            #1;
            chk("tab_resp_valid", in_resp_valid, rtab[v].exp_v);
            chk("tab_resp_tag", in_resp_tag, rtab[v].exp_tag);
            chk("tab_resp_data", in_resp_data, rtab[v].data);
            chk("tab_busy_sat", io_busy, 1'b0);
            @(negedge clk);
        end
        resp(1'b0, 10'd0);

        // Fairness: both valid, cache always ready -> 0,1,0,1
        do_reset();
        setreq(0, 1'b1, 8'hA0); setreq(1, 1'b1, 8'hB1); apply();
        io_mem_req_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("fair_valid", io_mem_req_valid, 1'b1);
            chk("fair_tag", io_mem_req_bits_tag, (c % 2 == 0) ? 10'h0A0 : 10'h1B1);
            chk("fair_ready", in_req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
            chk("fair_addr", io_mem_req_bits_addr, (c % 2 == 0) ? r_addr[0] : r_addr[1]);
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk("fair_busy_outstanding", io_busy, 1'b1);

        // Hold: source 1 stalls 3 cycles while source 0 asks too
        do_reset();
        setreq(1, 1'b1, 8'h5C); apply();
        for (int c = 0; c < 4; c++) begin
            io_mem_req_ready = (c == 3);
            if (c == 1) begin
                setreq(0, 1'b1, 8'h3D); apply();
            end
            #1;
            chk("hold_valid", io_mem_req_valid, 1'b1);
            chk("hold_tag", io_mem_req_bits_tag, 10'h15C);
            chk("hold_addr", io_mem_req_bits_addr, r_addr[1]);
            chk("hold_ready", in_req_ready, (c == 3) ? 2'b10 : 2'b00);
            @(negedge clk);
        end
        setreq(1, 1'b0, 8'h00); apply();
        #1;
        chk("hold_next_tag", io_mem_req_bits_tag, 10'h03D);
        chk("hold_next_ready", in_req_ready, 2'b01);

        // Throttle: four loads from source 0 exhaust its budget
        do_reset();
        setreq(0, 1'b1, 8'h40); apply();
        io_mem_req_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("thr_fill_ready", in_req_ready, 2'b01);
            @(negedge clk);
        end
        setreq(1, 1'b1, 8'h77); apply();
        #1;
        chk("thr_other_ready", in_req_ready, 2'b10);
        chk("thr_other_tag", io_mem_req_bits_tag, 10'h177);
        @(negedge clk);
        setreq(1, 1'b0, 8'h00); apply();
        #1;
        chk("thr_blocked_valid", io_mem_req_valid, 1'b0);
        chk("thr_blocked_ready", in_req_ready, 2'b00);
        @(negedge clk);
        resp(1'b1, 10'h005);
        #1;
        chk("thr_resp_valid", in_resp_valid, 2'b01);
        chk("thr_resp_tag", in_resp_tag, 8'h05);
        chk("thr_still_blocked", io_mem_req_valid, 1'b0);
        @(negedge clk);
        resp(1'b0, 10'd0);
        #1;
        chk("thr_unblocked_ready", in_req_ready, 2'b01);

        // Same-cycle fire and response from source 0
        do_reset();
        setreq(0, 1'b1, 8'h61); apply();
        io_mem_req_ready = 1'b1;
        #1;
        chk("sim_first_fire", in_req_ready, 2'b01);
        @(negedge clk);
        resp(1'b1, 10'h033);
        #1;
        chk("sim_fire", in_req_ready, 2'b01);
        chk("sim_resp", in_resp_valid, 2'b01);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("sim_busy_pending", io_busy, 1'b1);
        @(negedge clk);
        resp(1'b1, 10'h034);
        #1;
        chk("sim_busy_last_resp", io_busy, 1'b1);
        @(negedge clk);
        resp(1'b0, 10'd0);
        #1;
        chk("sim_busy_done", io_busy, 1'b0);

        // Asynchronous reset while a stalled request is on the bus
        do_reset();
        setreq(0, 1'b1, 8'h01); apply();
        io_mem_req_ready = 1'b1;
        @(negedge clk);
        setreq(0, 1'b0, 8'h00); setreq(1, 1'b1, 8'h02); apply();
        io_mem_req_ready = 1'b0;
        #1;
        chk("rsth_valid_before", io_mem_req_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("rsth_valid", io_mem_req_valid, 1'b0);
        chk("rsth_ready", in_req_ready, 2'b00);
        chk("rsth_busy", io_busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1;
        chk("rsth_cnt_clear", io_busy, 1'b0);
        @(negedge clk);
        setreq(0, 1'b1, 8'h0A); setreq(1, 1'b1, 8'h0B); apply();
        io_mem_req_ready = 1'b1;
        #1;
        chk("rsth_first_winner", in_req_ready, 2'b01);
        chk("rsth_first_tag", io_mem_req_bits_tag, 10'h00A);

`ifdef ROCC_MEM_ARB_STATS_EN
        // Grant statistics
        do_reset();
        setreq(1, 1'b1, 8'h99); apply();
        io_mem_req_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            resp(1'b1, 10'h100);
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk("stat_src1", io_stat_grants[31:16], 16'd5);
        chk("stat_src0", io_stat_grants[15:0], 16'd0);
        setreq(1, 1'b1, 8'h98); apply();
        io_mem_req_ready = 1'b1;
        stat_clear = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("stat_clear_wins", io_stat_grants[31:16], 16'd0);
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int s = 0; s < NREQ; s++) m_cnt[s] = 0;
        m_last = NREQ - 1;
        m_lock = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int s = 0; s < NREQ; s++) begin
                if (!r_v[s] && ($urandom_range(1, 0) == 1)) begin
                    r_v[s]    = 1'b1;
                    r_tag[s]  = 8'($urandom);
                    r_addr[s] = {8'($urandom), 32'($urandom)};
                    r_cmd[s]  = 5'($urandom);
                    r_typ[s]  = 3'($urandom);
                    r_data[s] = {32'($urandom), 32'($urandom)};
                end
            end
            apply();
            io_mem_req_ready = ($urandom_range(3, 0) != 0);
            rid = int'($urandom_range(3, 0));
            io_mem_resp_valid     = ($urandom_range(2, 0) == 0);
            io_mem_resp_bits_tag  = {2'(rid), 8'($urandom)};
            io_mem_resp_bits_data = {32'($urandom), 32'($urandom)};

            // The locked source is served alone; otherwise scan after the last winner
            ev = 1'b0;
            es = 0;
            if (m_lock >= 0) begin
                es = m_lock;
                ev = r_v[es];
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (!ev && r_v[(m_last + k) % NREQ] && (m_cnt[(m_last + k) % NREQ] < MAX_OUT)) begin
                        ev = 1'b1;
                        es = (m_last + k) % NREQ;
                    end
                end
            end
            efire = ev && io_mem_req_ready;
            er  = 2'b00;
            erv = 2'b00;
            if (efire) er[es] = 1'b1;
            if (io_mem_resp_valid && rid < NREQ) erv[rid] = 1'b1;

            #1;
            chk("rnd_valid", io_mem_req_valid, ev);
            chk("rnd_ready", in_req_ready, er);
            chk("rnd_resp_valid", in_resp_valid, erv);
            chk("rnd_resp_tag", in_resp_tag, io_mem_resp_bits_tag[7:0]);
            chk("rnd_busy", io_busy, ev || (m_cnt[0] != 0) || (m_cnt[1] != 0));
            if (ev) begin
                chk("rnd_tag", io_mem_req_bits_tag, {2'(es), r_tag[es]});
                chk("rnd_addr", io_mem_req_bits_addr, r_addr[es]);
                chk("rnd_cmd", io_mem_req_bits_cmd, r_cmd[es]);
                chk("rnd_typ", io_mem_req_bits_typ, r_typ[es]);
                chk("rnd_data", io_mem_req_bits_data, r_data[es]);
            end

            for (int s = 0; s < NREQ; s++) begin
                if (er[s] && !erv[s]) m_cnt[s] = m_cnt[s] + 1;
                else if (erv[s] && !er[s] && m_cnt[s] > 0) m_cnt[s] = m_cnt[s] - 1;
            end
            if (efire) begin
                m_last = es;
                m_lock = -1;
            end else if (ev) begin
                m_lock = es;
            end else begin
                m_lock = -1;
            end

            @(negedge clk);
            if (efire) r_v[es] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rocc_mem_arbiter.md
Name: rocc_mem_arbiter

Overview:
- Shares the single RoCC L1 data-cache request/response port among NREQ accelerator engines inside one accelerator tile.
- Arbitrates requests round-robin and prefixes each request tag with the source ID.
- Steers cache responses back to the source named by the tag prefix.
- Tracks outstanding loads per source and throttles a source once it reaches its limit.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- TAGW, 8, requester tag width; downstream tag is 10 bits: {2-bit source ID, 8-bit tag}.
- MAX_OUT, 4, max outstanding requests per requester; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_req_valid  in  NREQ  per-source request valid
- in_req_ready  out  NREQ  per-source request accepted
- in_req_addr  in  NREQ*40  flattened addresses; source i at [40i+39:40i]
- in_req_tag  in  NREQ*TAGW  flattened tags
- in_req_cmd  in  NREQ*5  flattened memory commands
- in_req_typ  in  NREQ*3  flattened access types
- in_req_data  in  NREQ*64  flattened store data
- io_mem_req_ready  in  1  cache accepts request
- io_mem_req_valid  out  1  request to cache
- io_mem_req_bits_addr  out  40  muxed address
- io_mem_req_bits_tag  out  10  {src[1:0], tag[7:0]}
- io_mem_req_bits_cmd  out  5  muxed command
- io_mem_req_bits_typ  out  3  muxed type
- io_mem_req_bits_phys  out  1  constant 1
- io_mem_req_bits_data  out  64  muxed store data
- io_mem_resp_valid  in  1  cache response valid
- io_mem_resp_bits_tag  in  10  response tag
- io_mem_resp_bits_data  in  64  response data
- in_resp_valid  out  NREQ  one-hot response strobe per source
- in_resp_tag  out  TAGW  io_mem_resp_bits_tag[7:0], broadcast to all sources
- in_resp_data  out  64  response data, broadcast to all sources
- io_busy  out  1  io_mem_req_valid, or any outstanding count nonzero

Behaviour:
- Reset (asynchronous):
  - state=IDLE, rr_ptr=NREQ-1, all cnt[i]=0, grant=0.
  - io_mem_req_valid=0, in_req_ready=0, in_resp_valid=0, io_busy=0.
- Eligibility: elig[i] = in_req_valid[i] & (cnt[i] < MAX_OUT).
- IDLE:
  - Winner is the first eligible source scanning rr_ptr+1, rr_ptr+2, ... modulo NREQ. This is a combinational, zero-cycle path.
  - io_mem_req_valid = any elig; request fields come from the winner.
  - in_req_ready[winner] = io_mem_req_ready; all other readies are 0.
  - If the request fires (valid & ready): rr_ptr<=winner, stay in IDLE.
  - If valid & !ready: grant<=winner, go to HOLD.
- HOLD:
  - Only source grant is forwarded, with no re-arbitration.
  - io_mem_req_valid = in_req_valid[grant].
  - Requesters must keep valid and fields stable until accepted.
  - On fire: rr_ptr<=grant, go to IDLE.
  - If in_req_valid[grant] drops (protocol violation), return to IDLE with no count change.
- Outstanding counters, per source i:
  - +1 on request fire from i.
  - -1 on io_mem_resp_valid with tag[9:8]==i.
  - Both in the same cycle: unchanged.
  - Decrement at 0 saturates at 0.
  - Counter width is 4 bits.
- Response path (combinational, zero latency):
  - in_resp_valid[i] = io_mem_resp_valid & (tag[9:8]==i).
  - A source ID >= NREQ produces no strobe and no counter change.
- A response may arrive in the same cycle as a request fire from the same source; both updates apply as above.
- Reset asserted mid-HOLD: the pending request is dropped, and counters clear even if responses are still in flight. Late responses then hit the saturating-decrement rule.

Optional Feature:
- Macro: ROCC_MEM_ARB_STATS_EN.
- When defined:
  - Adds output io_stat_grants, NREQ*16 bits.
  - Holds per-source 16-bit grant counters that increment on each fire, saturate at 16'hFFFF, and clear on reset.
  - Adds input stat_clear (1 bit), a synchronous clear of all counters; stat_clear has priority over a simultaneous increment.
- When undefined: neither port exists and no counter flops are built.

Test Plan:
- Fairness: NREQ=2, both valid every cycle, io_mem_req_ready=1 -> grants alternate 0,1,0,1; io_mem_req_bits_tag = {2'd0,tag0}, then {2'd1,tag1}.
- Hold: source 1 wins with ready=0 for 3 cycles while source 0 raises valid -> grant stays on 1, fields stable; fires on cycle 4; source 0 fires next.
- Throttle: MAX_OUT=4, source 0 issues 4 loads with no responses -> in_req_ready[0]=0 and source 1 still served; one response with tag 10'h0_05 -> in_resp_valid=2'b01, in_resp_tag=8'h05, source 0 eligible again.
- Simultaneous: source 0 fires in the same cycle as a response tagged source 0 -> cnt[0] unchanged; io_busy stays 1 until the last response arrives, then 0.
- Reset in HOLD: reset asserted asynchronously while io_mem_req_valid=1 -> outputs low immediately, counters 0; after release, source 0 wins first.
- With ROCC_MEM_ARB_STATS_EN: 5 fires from source 1 -> io_stat_grants[31:16]=16'd5; stat_clear asserted in the same cycle as a fire -> 16'd0.
